// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable width, parity and stop bits.
// Majority-voted sampling, start-glitch rejection, framing/parity flags.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] S0   = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] S1   = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] S2   = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LIDX = IW'(DATA_BITS - 1);
  localparam logic          LSTP = 1'(STOP_BITS - 1);
  localparam logic          ODD  = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t state, stateN;

  logic                 rxMeta, rxs;
  logic [CW-1:0]        cnt, cntN, cntInc;
  logic [IW-1:0]        idx, idxN;
  logic                 stopIdx, stopIdxN;
  logic                 s0, s0N, s1, s1N;
  logic [DATA_BITS-1:0] shiftReg, shiftN;
  logic                 perr, perrN, ferr, ferrN;
  logic                 seenHigh, seenHighN;
  logic                 done, maj, atEnd;

  assign maj     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign atEnd   = (cnt == LAST);
  assign cntInc  = atEnd ? '0 : cnt + CW'(1);
  assign rx_busy = (state != IDLE);

  // Two-flop synchroniser; idles high so reset looks like a quiet line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= rx_in;
      rxs    <= rxMeta;
    end
  end

  // Frame state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      stopIdx  <= 1'b0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      shiftReg <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      seenHigh <= 1'b0;
    end else begin
      state    <= stateN;
      cnt      <= cntN;
      idx      <= idxN;
      stopIdx  <= stopIdxN;
      s0       <= s0N;
      s1       <= s1N;
      shiftReg <= shiftN;
      perr     <= perrN;
      ferr     <= ferrN;
      seenHigh <= seenHighN;
    end
  end

  // Output registers; rx_valid drops on the very next clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_valid <= done;
      if (done) begin
        rx_data    <= shiftReg;
        frame_err  <= ferrN;
        parity_err <= perr;
      end
    end
  end

  // Next-state and sampling decisions, gated by the oversample tick
  always_comb begin
    stateN    = state;
    cntN      = cnt;
    idxN      = idx;
    stopIdxN  = stopIdx;
    s0N       = s0;
    s1N       = s1;
    shiftN    = shiftReg;
    perrN     = perr;
    ferrN     = ferr;
    seenHighN = seenHigh;
    done      = 1'b0;

    if (state == IDLE && rxs) seenHighN = 1'b1;

    if (baud_tick) begin
      if (cnt == S0) s0N = rxs;
      if (cnt == S1) s1N = rxs;
      unique case (state)
        IDLE: begin
          if (!rxs && seenHigh) begin
            stateN   = START;
            cntN     = '0;
            perrN    = 1'b0;
            ferrN    = 1'b0;
            stopIdxN = 1'b0;
          end
        end
        START: begin
          cntN = cntInc;
          if (cnt == S2 && maj) begin
            stateN = IDLE;
            cntN   = '0;
          end else if (atEnd) begin
            stateN = DATA;
            idxN   = '0;
          end
        end
        DATA: begin
          cntN = cntInc;
          if (cnt == S2) shiftN[idx] = maj;
          if (atEnd) begin
            if (idx == LIDX)
              stateN = (PARITY != 0) ? PAR : STOP;
            else
              idxN = idx + IW'(1);
          end
        end
        PAR: begin
          cntN = cntInc;
          if (cnt == S2 && (maj != ((^shiftReg) ^ ODD)))
            perrN = 1'b1;
          if (atEnd) stateN = STOP;
        end
        STOP: begin
          cntN = cntInc;
          if (cnt == S2) begin
            if (!maj) ferrN = 1'b1;
            if (stopIdx == LSTP) begin
              stateN = IDLE;
              cntN   = '0;
              done   = 1'b1;
              if (ferrN) seenHighN = 1'b0;
            end
          end else if (atEnd) begin
            stopIdxN = 1'b1;
          end
        end
        default: stateN = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param.
// 8N1 instance on line A, 8E1 instance on line B.
module tb_uart_rx_param;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rxA = 1'b1;
  logic       rxB = 1'b1;
  logic [7:0] dataA, dataB;
  logic       vA, vB, feA, feB, peA, peB, busyA, busyB;

  exp_t qA[$];
  exp_t qB[$];
  exp_t eA, eB;
  logic pvA = 1'b0;
  logic pvB = 1'b0;

  int tests = 0;
  int fails = 0;

  uart_rx_param #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)
  ) dutA (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rxA),
    .rx_data(dataA), .rx_valid(vA), .frame_err(feA),
    .parity_err(peA), .rx_busy(busyA)
  );

  uart_rx_param #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)
  ) dutB (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rxB),
    .rx_data(dataB), .rx_valid(vB), .frame_err(feB),
    .parity_err(peB), .rx_busy(busyB)
  );

  always #5 clk = ~clk;

  // Baud tick every third clk, changed away from the active edge
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      baud_tick = (div == 0);
      div = (div == 2) ? 0 : div + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic waitTicks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic setLine(input int w, input logic v);
    if (w == 0) rxA = v;
    else rxB = v;
  endtask

  // par < 0: no parity bit; otherwise par[0] is the bit sent
  task automatic sendFrame(input int w, input logic [7:0] d,
                           input int par, input logic stopV);
    exp_t e;
    e.d  = d;
    e.fe = !stopV;
    e.pe = (par >= 0) ? (par[0] != (^d)) : 1'b0;
    if (w == 0) qA.push_back(e);
    else qB.push_back(e);
    setLine(w, 1'b0);
    waitTicks(16);
    for (int i = 0; i < 8; i++) begin
      setLine(w, d[i]);
      waitTicks(16);
    end
    if (par >= 0) begin
      setLine(w, par[0]);
      waitTicks(16);
    end
    setLine(w, stopV);
    waitTicks(16);
  endtask

  // Line A output checker
  always @(negedge clk) begin
    if (vA) begin
      chk("A_width", 32'(pvA), 32'd0);
      chk("A_busy", 32'(busyA), 32'd0);
      if (qA.size() == 0) begin
        chk("A_extra", 32'(qA.size()), 32'd1);
      end else begin
        eA = qA.pop_front();
        chk("A_data", 32'(dataA), 32'(eA.d));
        chk("A_ferr", 32'(feA), 32'(eA.fe));
        chk("A_perr", 32'(peA), 32'(eA.pe));
      end
    end
    pvA = vA;
  end

  // Line B output checker
  always @(negedge clk) begin
    if (vB) begin
      chk("B_width", 32'(pvB), 32'd0);
      chk("B_busy", 32'(busyB), 32'd0);
      if (qB.size() == 0) begin
        chk("B_extra", 32'(qB.size()), 32'd1);
      end else begin
        eB = qB.pop_front();
        chk("B_data", 32'(dataB), 32'(eB.d));
        chk("B_ferr", 32'(feB), 32'(eB.fe));
        chk("B_perr", 32'(peB), 32'(eB.pe));
      end
    end
    pvB = vB;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dataA", 32'(dataA), 32'd0);
    chk("rst_validA", 32'(vA), 32'd0);
    chk("rst_feA", 32'(feA), 32'd0);
    chk("rst_peA", 32'(peA), 32'd0);
    chk("rst_busyA", 32'(busyA), 32'd0);
    chk("rst_dataB", 32'(dataB), 32'd0);
    chk("rst_busyB", 32'(busyB), 32'd0);
    rst = 1'b0;
    waitTicks(32);

    // Back-to-back frames
    sendFrame(0, 8'h55, -1, 1'b1);
    sendFrame(0, 8'hC3, -1, 1'b1);
    setLine(0, 1'b1);
    waitTicks(32);

    // Short low glitch on idle line: start aborted
    setLine(0, 1'b0);
    waitTicks(4);
    chk("glitch_busy", 32'(busyA), 32'd1);
    setLine(0, 1'b1);
    waitTicks(16);
    chk("glitch_idle", 32'(busyA), 32'd0);
    chk("glitch_data", 32'(dataA), 32'hC3);
    waitTicks(16);

    // Parity instance: wrong then correct parity
    sendFrame(1, 8'hA3, 1, 1'b1);
    setLine(1, 1'b1);
    waitTicks(16);
    sendFrame(1, 8'h03, 0, 1'b1);
    setLine(1, 1'b1);
    waitTicks(32);

    // 0x00 with a one-tick high glitch mid data bit 3
    eA.d = 8'h00; eA.fe = 1'b0; eA.pe = 1'b0;
    qA.push_back(eA);
    setLine(0, 1'b0);
    waitTicks(16);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        waitTicks(8);
        setLine(0, 1'b1);
        waitTicks(1);
        setLine(0, 1'b0);
        waitTicks(7);
      end else begin
        waitTicks(16);
      end
    end
    setLine(0, 1'b1);
    waitTicks(32);

    // Stop bit low, then line stuck low for 5 frames
    sendFrame(0, 8'h7E, -1, 1'b0);
    waitTicks(800);
    chk("stuck_busy", 32'(busyA), 32'd0);
    setLine(0, 1'b1);
    waitTicks(32);
    sendFrame(0, 8'h21, -1, 1'b1);
    setLine(0, 1'b1);
    waitTicks(32);

    // Reset during data bit 4 of 0xFF
    setLine(0, 1'b0);
    waitTicks(16);
    setLine(0, 1'b1);
    waitTicks(64 + 8);
    chk("mid_busy", 32'(busyA), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_data", 32'(dataA), 32'd0);
    chk("mrst_valid", 32'(vA), 32'd0);
    chk("mrst_fe", 32'(feA), 32'd0);
    chk("mrst_pe", 32'(peA), 32'd0);
    chk("mrst_busy", 32'(busyA), 32'd0);
    #9;
    rst = 1'b0;
    waitTicks(8 + 48 + 16 + 48);
    chk("mrst_quiet", 32'(busyA), 32'd0);
    sendFrame(0, 8'h5A, -1, 1'b1);
    setLine(0, 1'b1);
    waitTicks(48);

    chk("A_left", 32'(qA.size()), 32'd0);
    chk("B_left", 32'(qB.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
